// File: rtl/pixel_array_ctrl.sv
// pixel_array_ctrl: sequencer for a 4-pixel array.
// Drives ERASE -> EXPOSE -> CONVERT (ramp count on DATA) -> READ0..3 -> DONE,
// captures each pixel value from DATA and presents it with a valid pulse.
// Every output is a register loaded from the next-state decode, so each
// strobe changes cleanly on a clock edge and drops at once on reset.
// Optional build macro: GRAY_COUNTER_EN. When defined, the count is driven
// Gray-coded and captured values are converted back to binary.
module pixel_array_ctrl #(
  parameter int C_ERASE  = 5,
  parameter int C_EXPOSE = 255,
  parameter int C_READ   = 5,
  parameter int COUNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               erase,
  output logic               expose,
  output logic               convert,
  output logic [3:0]         read,
  output logic               data_oe,
  output logic [COUNT_W-1:0] data_out,
  input  logic [COUNT_W-1:0] data_in,
  output logic [COUNT_W-1:0] pixel_data,
  output logic [1:0]         pixel_idx,
  output logic               pixel_valid,
  output logic               frame_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ERASE   = 3'd1;
  localparam logic [2:0] S_EXPOSE  = 3'd2;
  localparam logic [2:0] S_CONVERT = 3'd3;
  localparam logic [2:0] S_READ    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Last value of the phase counter in each timed state.
  localparam logic [31:0] ERASE_LAST  = 32'(C_ERASE - 1);
  localparam logic [31:0] EXPOSE_LAST = 32'(C_EXPOSE - 1);
  localparam logic [31:0] CONV_LAST   = 32'((64'd1 << COUNT_W) - 64'd1);
  localparam logic [31:0] READ_LAST   = 32'(C_READ - 1);

`ifdef GRAY_COUNTER_EN
  function automatic logic [COUNT_W-1:0] enc_count(input logic [COUNT_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [COUNT_W-1:0] dec_data(input logic [COUNT_W-1:0] g);
    logic [COUNT_W-1:0] b;
    b[COUNT_W-1] = g[COUNT_W-1];
    for (int i = COUNT_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
`else
  function automatic logic [COUNT_W-1:0] enc_count(input logic [COUNT_W-1:0] b);
    return b;
  endfunction

  function automatic logic [COUNT_W-1:0] dec_data(input logic [COUNT_W-1:0] g);
    return g;
  endfunction
`endif

  logic [2:0]  state, state_next;
  logic [31:0] phase, phase_next;
  logic [1:0]  rsel, rsel_next;
  logic        capture;

  // Next-state, phase counter and pixel select; phase restarts at 0 on
  // every state change so the CONVERT count starts from zero.
  always_comb begin
    state_next = state;
    phase_next = phase;
    rsel_next  = rsel;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_ERASE;
          phase_next = '0;
        end
      end
      S_ERASE: begin
        if (phase == ERASE_LAST) begin
          state_next = S_EXPOSE;
          phase_next = '0;
        end else begin
          phase_next = phase + 32'd1;
        end
      end
      S_EXPOSE: begin
        if (phase == EXPOSE_LAST) begin
          state_next = S_CONVERT;
          phase_next = '0;
        end else begin
          phase_next = phase + 32'd1;
        end
      end
      S_CONVERT: begin
        if (phase == CONV_LAST) begin
          state_next = S_READ;
          phase_next = '0;
          rsel_next  = 2'd0;
        end else begin
          phase_next = phase + 32'd1;
        end
      end
      S_READ: begin
        if (phase == READ_LAST) begin
          // This edge ends the last READ cycle of the current pixel.
          capture    = 1'b1;
          phase_next = '0;
          if (rsel == 2'd3) begin
            state_next = S_DONE;
          end else begin
            rsel_next = rsel + 2'd1;
          end
        end else begin
          phase_next = phase + 32'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        phase_next = '0;
        rsel_next  = 2'd0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      phase <= '0;
      rsel  <= 2'd0;
    end else begin
      state <= state_next;
      phase <= phase_next;
      rsel  <= rsel_next;
    end
  end

  // Moore outputs, registered from the next-state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      data_oe    <= 1'b0;
      data_out   <= '0;
      read       <= 4'b0000;
      frame_done <= 1'b0;
    end else begin
      busy       <= (state_next != S_IDLE);
      erase      <= (state_next == S_ERASE);
      expose     <= (state_next == S_EXPOSE);
      convert    <= (state_next == S_CONVERT);
      data_oe    <= (state_next == S_CONVERT);
      data_out   <= (state_next == S_CONVERT) ? enc_count(phase_next[COUNT_W-1:0]) : '0;
      read       <= (state_next == S_READ) ? (4'b0001 << rsel_next) : 4'b0000;
      frame_done <= (state_next == S_DONE);
    end
  end

  // Pixel capture; value and index hold until the next capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_data  <= '0;
      pixel_idx   <= 2'd0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= capture;
      if (capture) begin
        pixel_data <= dec_data(data_in);
        pixel_idx  <= rsel;
      end
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb_pixel_array_ctrl: directed bench for pixel_array_ctrl with
// C_ERASE=3, C_EXPOSE=4, C_READ=2. Expected strobes follow the frame
// schedule indexed by cycle number k from the first ERASE cycle.
// Honors GRAY_COUNTER_EN the same way as the design.
module tb_pixel_array_ctrl;
  localparam int CE = 3;
  localparam int CX = 4;
  localparam int CR = 2;
  localparam int T_CONV = CE + CX;          // first CONVERT cycle
  localparam int T_READ = T_CONV + 256;     // first READ cycle
  localparam int T_DONE = T_READ + 4 * CR;  // DONE cycle (272nd cycle)

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, erase, expose, convert, data_oe, pixel_valid, frame_done;
  logic [3:0] read;
  logic [7:0] data_out, pixel_data;
  logic [7:0] data_in = 8'h00;
  logic [1:0] pixel_idx;

  int total = 0;
  int bad = 0;
  logic [7:0] vals [4];

  pixel_array_ctrl #(.C_ERASE(CE), .C_EXPOSE(CX), .C_READ(CR), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .erase(erase),
    .expose(expose), .convert(convert), .read(read), .data_oe(data_oe),
    .data_out(data_out), .data_in(data_in), .pixel_data(pixel_data),
    .pixel_idx(pixel_idx), .pixel_valid(pixel_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input int b);
`ifdef GRAY_COUNTER_EN
    return 8'(b ^ (b >> 1));
`else
    return 8'(b);
`endif
  endfunction

  // Walks one full frame cycle by cycle, starting at the negedge of the
  // first ERASE cycle and ending at the negedge of the following IDLE cycle.
  task automatic run_frame(input logic hold, input string tag);
    logic [18:0] obs, exp;
    logic        e_conv;
    logic [3:0]  e_read;
    int          p;
    for (int k = 0; k <= T_DONE; k++) begin
      e_conv = (k >= T_CONV) && (k < T_READ);
      e_read = ((k >= T_READ) && (k < T_DONE)) ? 4'(1 << ((k - T_READ) / CR)) : 4'b0000;
      exp = {1'b1, 1'(k < CE), 1'((k >= CE) && (k < T_CONV)), e_conv, e_read, e_conv,
             (e_conv ? enc(k - T_CONV) : 8'h00), 1'(k == T_DONE),
             1'((k > T_READ) && (k <= T_DONE) && (((k - T_READ) % CR) == 0))};
      obs = {busy, erase, expose, convert, read, data_oe, data_out, frame_done, pixel_valid};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s_ctrl k=%0d got=%h exp=%h", tag, k, obs, exp);
      end
      if ((k > T_READ) && (k <= T_DONE) && (((k - T_READ) % CR) == 0)) begin
        p = (k - T_READ) / CR - 1;
        total++;
        if ({pixel_idx, pixel_data} !== {2'(p), vals[p]}) begin
          bad++;
          $display("FAIL %s_pixel k=%0d got idx=%0d data=%h exp idx=%0d data=%h",
                   tag, k, pixel_idx, pixel_data, p, vals[p]);
        end
      end
      // Real value only on the last READ cycle of a pixel; filler elsewhere.
      if ((k >= T_READ) && (k < T_DONE) && (((k - T_READ) % CR) == CR - 1))
        data_in = enc(int'(vals[(k - T_READ) / CR]));
      else
        data_in = 8'h5A;
      start = hold;
      @(negedge clk);
    end
    total++;
    if ({busy, erase, frame_done, pixel_valid, pixel_idx, pixel_data} !== {4'b0000, 2'd3, vals[3]}) begin
      bad++;
      $display("FAIL %s_idle got busy=%b erase=%b fd=%b pv=%b idx=%0d data=%h exp 0 0 0 0 3 %h",
               tag, busy, erase, frame_done, pixel_valid, pixel_idx, pixel_data, vals[3]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, erase, expose, convert, read, data_oe, data_out, pixel_data, pixel_idx,
         pixel_valid, frame_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b erase=%b conv=%b read=%b dout=%h pdata=%h exp all 0",
               busy, erase, convert, read, data_out, pixel_data);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, erase} !== 2'b00) begin
      bad++;
      $display("FAIL reset_release got busy=%b erase=%b exp 0 0", busy, erase);
    end
  endtask

  task automatic test_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_frame(1'b0, "frame");
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (T_CONV + 8'h40) @(negedge clk);
    total++;
    if ({convert, data_oe, data_out} !== {2'b11, enc(8'h40)}) begin
      bad++;
      $display("FAIL midrst_pre got conv=%b oe=%b dout=%h exp 1 1 %h",
               convert, data_oe, data_out, enc(8'h40));
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({busy, convert, data_oe, data_out, pixel_data} !== '0) begin
      bad++;
      $display("FAIL midrst_async got busy=%b conv=%b oe=%b dout=%h pdata=%h exp all 0",
               busy, convert, data_oe, data_out, pixel_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, erase, convert} !== 3'b000) begin
      bad++;
      $display("FAIL midrst_idle got busy=%b erase=%b conv=%b exp 0 0 0", busy, erase, convert);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_frame(1'b0, "restart");
  endtask

  task automatic test_back_to_back();
    vals[0] = 8'h2A; vals[1] = 8'h01; vals[2] = 8'hFF; vals[3] = 8'h7E;
    start = 1'b1;
    @(negedge clk);
    run_frame(1'b1, "b2b_a");
    @(negedge clk);
    run_frame(1'b0, "b2b_b");
  endtask

  initial begin
    vals[0] = 8'h33; vals[1] = 8'h80; vals[2] = 8'hE6; vals[3] = 8'h80;
    test_reset();
    test_frame();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end

endmodule
